// File: rtl/syx_param_parser_pkg.sv
// Shared synth package: MIDI status constants, command codes,
// parser state encoding and the write bundle.
package syx_param_parser_pkg;

   localparam logic [7:0] SYX_START  = 8'hF0;
   localparam logic [7:0] SYX_END    = 8'hF7;
   localparam logic [7:0] RT_MIN     = 8'hF8;
   localparam logic [7:0] CMD_WR1    = 8'h10;
   localparam logic [7:0] CMD_WRBULK = 8'h11;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_MANUF,
      ST_DEV,
      ST_CMD,
      ST_BANK,
      ST_ADR,
      ST_DHI,
      ST_DLO,
      ST_EOX,
      ST_SKIP
   } syx_state_t;

   typedef struct packed {
      logic [2:0] bank;
      logic [6:0] param;
      logic [7:0] data;
   } syx_wr_t;

endpackage

// File: rtl/syx_wr_strobe.sv
// Write strobe: one-deep queue plus data_ready pulse counter.
// Outputs only change on the edge that raises data_ready.
module syx_wr_strobe
   import syx_param_parser_pkg::*;
#(
   parameter int DRDY_CYCLES = 8
) (
   input  logic    reg_clk,
   input  logic    reset_reg_N,
   input  logic    wr_req,
   input  syx_wr_t wr_in,
   input  logic    flush,
   output logic    data_ready,
   output syx_wr_t wr_out,
   output logic    ovf
);

   localparam int CW = $clog2(DRDY_CYCLES);
   localparam logic [CW-1:0] LOAD = CW'(DRDY_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic          q_vld;
   syx_wr_t       q;

   assign ovf = wr_req && data_ready && q_vld;

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         data_ready <= 1'b0;
         cnt        <= '0;
         wr_out     <= '0;
      end else if (data_ready) begin
         if (cnt == '0)
            data_ready <= 1'b0;
         else
            cnt <= cnt - 1'b1;
      end else if (q_vld) begin
         wr_out     <= q;
         data_ready <= 1'b1;
         cnt        <= LOAD;
      end else if (wr_req) begin
         wr_out     <= wr_in;
         data_ready <= 1'b1;
         cnt        <= LOAD;
      end
   end

   // Queue slot frees on the edge it issues, so a new pair may refill it
   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         q_vld <= 1'b0;
         q     <= '0;
      end else if (flush) begin
         q_vld <= 1'b0;
      end else if (!data_ready && q_vld) begin
         q_vld <= wr_req;
         if (wr_req)
            q <= wr_in;
      end else if (data_ready && !q_vld && wr_req) begin
         q_vld <= 1'b1;
         q     <= wr_in;
      end
   end

endmodule

// File: rtl/syx_param_parser.sv
// SysEx parameter parser: frames F0 ID DEV CMD BANK ADR {DHI DLO}* F7
// into bank/param/data writes with a stretched data_ready strobe.
module syx_param_parser
   import syx_param_parser_pkg::*;
#(
   parameter logic [7:0] MANUF_ID    = 8'h7D,
   parameter int         NUM_BANKS   = 6,
   parameter int         DRDY_CYCLES = 8
) (
   input  logic       reg_clk,
   input  logic       reset_reg_N,
   input  logic [3:0] dev_id,
   input  logic       midi_rdy,
   input  logic [7:0] midi_byte,
   output logic       data_ready,
   output logic [2:0] bank_adr,
   output logic [6:0] param_adr,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       syx_err
);

   syx_state_t state, state_nxt;
   logic [2:0] bank_r;
   logic [6:0] param_r;
   logic       dhi0, bulk_r;
   logic       wr_req, err_set, flush, ovf;
   syx_wr_t    wr_in, wr_out;

   logic act, is_f0, is_f7, is_oth, is_dat;
   logic cmd_ok, bank_ok, f7_bad;

   assign act    = midi_rdy && (midi_byte < RT_MIN);
   assign is_f0  = midi_byte == SYX_START;
   assign is_f7  = midi_byte == SYX_END;
   assign is_dat = !midi_byte[7];
   assign is_oth = midi_byte[7] && !is_f0 && !is_f7;

   assign cmd_ok  = (midi_byte == CMD_WR1) ||
                    (midi_byte == CMD_WRBULK);
   assign bank_ok = int'(midi_byte) < NUM_BANKS;
   assign f7_bad  = !(state inside {ST_IDLE, ST_SKIP, ST_EOX}) &&
                    !(state == ST_DHI && bulk_r);

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (act) begin
         unique case (1'b1)
            is_f0:  state_nxt = ST_MANUF;
            is_f7:  state_nxt = ST_IDLE;
            is_oth: state_nxt = ST_IDLE;
            default: begin
               unique case (state)
                  ST_MANUF: state_nxt = (midi_byte == MANUF_ID) ?
                                        ST_DEV : ST_SKIP;
                  ST_DEV:   state_nxt = (midi_byte == {4'h0, dev_id}) ?
                                        ST_CMD : ST_SKIP;
                  ST_CMD:   state_nxt = cmd_ok ? ST_BANK : ST_SKIP;
                  ST_BANK:  state_nxt = bank_ok ? ST_ADR : ST_SKIP;
                  ST_ADR:   state_nxt = ST_DHI;
                  ST_DHI:   state_nxt = ST_DLO;
                  ST_DLO:   state_nxt = bulk_r ? ST_DHI : ST_EOX;
                  ST_EOX:   state_nxt = ST_SKIP;
                  default:  state_nxt = state;
               endcase
            end
         endcase
      end
   end

   always_comb begin
      busy    = state != ST_IDLE;
      wr_req  = 1'b0;
      err_set = 1'b0;
      flush   = 1'b0;
      if (act) begin
         unique case (1'b1)
            is_f0:  ;
            is_f7:  err_set = f7_bad;
            is_oth: begin
               err_set = busy;
               flush   = busy;
            end
            default: begin
               wr_req  = state == ST_DLO;
               err_set = (state == ST_CMD && !cmd_ok) ||
                         (state == ST_BANK && !bank_ok) ||
                         (state == ST_EOX);
            end
         endcase
      end
   end

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         bank_r  <= '0;
         param_r <= '0;
         dhi0    <= 1'b0;
         bulk_r  <= 1'b0;
      end else if (act && is_dat) begin
         unique case (state)
            ST_CMD:  bulk_r  <= midi_byte == CMD_WRBULK;
            ST_BANK: bank_r  <= midi_byte[2:0];
            ST_ADR:  param_r <= midi_byte[6:0];
            ST_DHI:  dhi0    <= midi_byte[0];
            ST_DLO:  param_r <= param_r + 7'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N)
         syx_err <= 1'b0;
      else if (act && is_f0)
         syx_err <= 1'b0;
      else if (err_set || ovf)
         syx_err <= 1'b1;
   end

   assign wr_in = {bank_r, param_r, dhi0, midi_byte[6:0]};

   syx_wr_strobe #(
      .DRDY_CYCLES (DRDY_CYCLES)
   ) u_strobe (
      .reg_clk     (reg_clk),
      .reset_reg_N (reset_reg_N),
      .wr_req      (wr_req),
      .wr_in       (wr_in),
      .flush       (flush),
      .data_ready  (data_ready),
      .wr_out      (wr_out),
      .ovf         (ovf)
   );

   assign bank_adr  = wr_out.bank;
   assign param_adr = wr_out.param;
   assign out_data  = wr_out.data;

endmodule
